shrimp_writeback: RTL and testbench
===================================

// Module: shrimp_writeback
// PURPOSE
//  Writeback stage directly upstream of the register file. Merges single-cycle ALU results and
//  variable-latency load responses onto the regfile's single write port. Load responses are buffered
//  in a small queue. A starvation counter guarantees loads retire. Exports a busy mask for decode stalls.
// PARAMETERS
//  LQ_DEPTH      2  load-queue entries; power of two, >= 2
//  STARVE_LIMIT  4  consecutive ALU-won cycles with non-empty queue before a forced load pop; >= 1
// PORTS
//  clock         in   1   sole clock, rising edge
//  reset_n       in   1   asynchronous, active-low reset
//  alu_valid     in   1   ALU result present this cycle (no backpressure except alu_stall)
//  alu_addr      in   4   ALU destination register
//  alu_val       in   16  ALU result
//  alu_stall     out  1   ALU result NOT accepted this cycle; upstream holds it
//  mem_valid     in   1   load response present
//  mem_ready     out  1   queue can accept a load response
//  mem_addr      in   4   load destination register
//  mem_val       in   16  load data
//  reg_w_enable  out  1   to regfile write enable
//  reg_w_addr    out  4   to regfile write address
//  reg_w_val     out  16  to regfile write data
//  busy_mask     out  16  bit r set = write to r queued or in the output stage
//  lq_count      out  $clog2(LQ_DEPTH)+1  current queue occupancy
// BEHAVIOUR
//  Reset (async, reset_n=0): reg_w_enable=0, reg_w_addr=0, reg_w_val=0, queue empty, lq_count=0,
//   starve counter=0, busy_mask=0, alu_stall=0, mem_ready=1. Takes effect immediately; in-flight data is lost.
//  Queue: FIFO with wrapping rd/wr pointers. mem_ready = (lq_count != LQ_DEPTH), from registered state.
//   A simultaneous pop does not free a slot in the same cycle.
//   Push on mem_valid && mem_ready && mem_addr!=4'hF.
//   mem_valid && mem_ready && mem_addr==4'hF: handshake completes, data is discarded, nothing is pushed.
//  Arbitration, each cycle, combinational from registered state:
//   force = (starve == STARVE_LIMIT) && queue non-empty
//   alu_stall = force && alu_valid
//   alu_win = alu_valid && !force && alu_addr != 4'hF
//   pop = queue non-empty && !alu_win
//   alu_valid with alu_addr==4'hF: accepted, discarded, leaves the port free for a pop.
//  Output register, loaded every edge: if alu_win -> {1, alu_addr, alu_val};
//   elif pop -> {1, head addr, head val}; else reg_w_enable=0 (addr/val hold).
//   The regfile commits on the following edge.
//   Latency: ALU in -> reg_w_enable high 1 cycle.
//   Load push at edge N -> earliest reg_w_enable at edge N+1 (pop next cycle), visible after N+2.
//  Starve counter: increments (saturating at STARVE_LIMIT) when alu_win && queue non-empty.
//   Clears on any pop or when queue empty.
//  Simultaneous push+pop: both occur; lq_count unchanged; pointers both advance, wrapping modulo LQ_DEPTH.
//  busy_mask = OR of onehot(addr) over valid queue entries, plus onehot(reg_w_addr) if reg_w_enable.
//   Bit 15 is always 0.
//  Ordering between ALU and load writes to the same register is decode's duty (stall on busy_mask);
//   this block performs no address comparison.
//  lq_count never exceeds LQ_DEPTH; pop on empty and push on full never occur.
// TESTING
//  1 ALU only: alu_valid, addr 3, val 0x1234 -> next cycle reg_w_enable=1, addr 3, val 0x1234;
//    busy_mask=0x0008.
//  2 Load alone: mem addr 5, val 0xBEEF, queue empty -> lq_count 1, then write {5,0xBEEF};
//    busy_mask bit5 set for 2 cycles.
//  3 Full queue: push 2 loads with ALU continuously valid -> mem_ready=0;
//    3rd mem_valid held until a slot frees; no data lost or reordered.
//  4 Starvation: queue holds {7,0xAAAA}, ALU valid every cycle -> after 4 ALU wins alu_stall=1
//    for 1 cycle and {7,0xAAAA} is written.
//  5 Zero reg: alu_addr=F with queue holding {2,0x0042} -> no ALU write, {2,0x0042} popped;
//    mem_addr=F -> accepted, lq_count unchanged.
//  6 Reset mid-op: assert reset_n=0 with 2 queued entries and reg_w_enable=1 -> all outputs to
//    reset values asynchronously; no write after release.

Source files
------------

// File: rtl/shrimp_writeback.sv
// Writeback stage: arbitrates single-cycle ALU results against queued load responses
// for the register file's single write port, with a starvation guard for loads.
module shrimp_writeback #(
    parameter int unsigned LQ_DEPTH     = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        alu_valid,
    input  logic [3:0]                  alu_addr,
    input  logic [15:0]                 alu_val,
    output logic                        alu_stall,
    input  logic                        mem_valid,
    output logic                        mem_ready,
    input  logic [3:0]                  mem_addr,
    input  logic [15:0]                 mem_val,
    output logic                        reg_w_enable,
    output logic [3:0]                  reg_w_addr,
    output logic [15:0]                 reg_w_val,
    output logic [15:0]                 busy_mask,
    output logic [$clog2(LQ_DEPTH):0]   lq_count
);

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned PTR_W = $clog2(LQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ST_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW-1:0] ZERO_REG = 4'hF;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] val;
    } wb_entry_t;

    wb_entry_t        q [LQ_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [ST_W-1:0]  starve;

    logic             q_empty;
    logic             force_pop;
    logic             alu_win;
    logic             pop;
    logic             push;
    logic [PTR_W-1:0] slot_off;

    // Arbitration is purely a function of registered state and current inputs.
    always_comb begin
        q_empty   = (count == '0);
        force_pop = (starve == ST_W'(STARVE_LIMIT)) && !q_empty;
        alu_win   = alu_valid && !force_pop && (alu_addr != ZERO_REG);
        pop       = !q_empty && !alu_win;
        push      = mem_valid && mem_ready && (mem_addr != ZERO_REG);
    end

    assign mem_ready = (count != CNT_W'(LQ_DEPTH));
    assign alu_stall = force_pop && alu_valid;
    assign lq_count  = count;

    // Queue payload storage; contents are only meaningful while counted as valid.
    always_ff @(posedge clock) begin
        if (push) begin
            q[wr_ptr] <= '{addr: mem_addr, val: mem_val};
        end
    end

    // Pointers and occupancy; pointers wrap naturally since depth is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Counts ALU wins while a load waits; saturates at the limit to force a pop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve <= '0;
        end else if (q_empty || pop) begin
            starve <= '0;
        end else if (alu_win && (starve != ST_W'(STARVE_LIMIT))) begin
            starve <= starve + ST_W'(1);
        end
    end

    // Output stage toward the register file; address/data hold when idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reg_w_enable <= 1'b0;
            reg_w_addr   <= '0;
            reg_w_val    <= '0;
        end else if (alu_win) begin
            reg_w_enable <= 1'b1;
            reg_w_addr   <= alu_addr;
            reg_w_val    <= alu_val;
        end else if (pop) begin
            reg_w_enable <= 1'b1;
            reg_w_addr   <= q[rd_ptr].addr;
            reg_w_val    <= q[rd_ptr].val;
        end else begin
            reg_w_enable <= 1'b0;
        end
    end

    // Pending-write mask for decode: live queue slots plus the output stage.
    always_comb begin
        busy_mask = '0;
        slot_off  = '0;
        for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
            slot_off = PTR_W'(i) - rd_ptr;
            if (CNT_W'(slot_off) < count) begin
                busy_mask[q[i].addr] = 1'b1;
            end
        end
        if (reg_w_enable) begin
            busy_mask[reg_w_addr] = 1'b1;
        end
        busy_mask[15] = 1'b0;
    end

endmodule

// File: tb/tb_shrimp_writeback.sv
// Directed bench for shrimp_writeback with hand-computed expectations.
module tb_shrimp_writeback;

    logic        clock;
    logic        reset_n;
    logic        alu_valid;
    logic [3:0]  alu_addr;
    logic [15:0] alu_val;
    logic        alu_stall;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_addr;
    logic [15:0] mem_val;
    logic        reg_w_enable;
    logic [3:0]  reg_w_addr;
    logic [15:0] reg_w_val;
    logic [15:0] busy_mask;
    logic [1:0]  lq_count;

    int n_vec;
    int n_err;

    shrimp_writeback #(.LQ_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .alu_valid    (alu_valid),
        .alu_addr     (alu_addr),
        .alu_val      (alu_val),
        .alu_stall    (alu_stall),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_val      (mem_val),
        .reg_w_enable (reg_w_enable),
        .reg_w_addr   (reg_w_addr),
        .reg_w_val    (reg_w_val),
        .busy_mask    (busy_mask),
        .lq_count     (lq_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_alu(input logic v, input logic [3:0] a, input logic [15:0] d);
        alu_valid = v;
        alu_addr  = a;
        alu_val   = d;
    endtask

    task automatic set_mem(input logic v, input logic [3:0] a, input logic [15:0] d);
        mem_valid = v;
        mem_addr  = a;
        mem_val   = d;
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [3:0] a, input logic [15:0] d);
        chk({tag, ".en"}, 32'(reg_w_enable), 32'(en));
        if (en) begin
            chk({tag, ".addr"}, 32'(reg_w_addr), 32'(a));
            chk({tag, ".val"}, 32'(reg_w_val), 32'(d));
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".en"}, 32'(reg_w_enable), 32'd0);
        chk({tag, ".addr"}, 32'(reg_w_addr), 32'd0);
        chk({tag, ".val"}, 32'(reg_w_val), 32'd0);
        chk({tag, ".cnt"}, 32'(lq_count), 32'd0);
        chk({tag, ".busy"}, 32'(busy_mask), 32'd0);
        chk({tag, ".stall"}, 32'(alu_stall), 32'd0);
        chk({tag, ".rdy"}, 32'(mem_ready), 32'd1);
    endtask

    logic [3:0]  rec_addr [8];
    logic [15:0] rec_val  [8];
    int          nrec;
    logic        hs;

    initial begin
        n_vec   = 0;
        n_err   = 0;
        nrec    = 0;
        hs      = 1'b0;
        reset_n = 1'b0;
        set_alu(1'b0, 4'h0, 16'h0);
        set_mem(1'b0, 4'h0, 16'h0);
        #3;
        chk_reset_state("rst");
        @(negedge clock);
        reset_n = 1'b1;

        // ALU only
        set_alu(1'b1, 4'h3, 16'h1234);
        tick();
        set_alu(1'b0, 4'h0, 16'h0);
        chk_wr("alu1", 1'b1, 4'h3, 16'h1234);
        chk("alu1.busy", 32'(busy_mask), 32'h0008);
        tick();
        chk_wr("alu1.idle", 1'b0, 4'h0, 16'h0);
        chk("alu1.idle.busy", 32'(busy_mask), 32'h0000);

        // Load alone
        set_mem(1'b1, 4'h5, 16'hBEEF);
        #1 chk("ld.rdy", 32'(mem_ready), 32'd1);
        tick();
        set_mem(1'b0, 4'h0, 16'h0);
        chk("ld.cnt1", 32'(lq_count), 32'd1);
        chk_wr("ld.q", 1'b0, 4'h0, 16'h0);
        chk("ld.busy.q", 32'(busy_mask), 32'h0020);
        tick();
        chk_wr("ld.wr", 1'b1, 4'h5, 16'hBEEF);
        chk("ld.cnt0", 32'(lq_count), 32'd0);
        chk("ld.busy.wr", 32'(busy_mask), 32'h0020);
        tick();
        chk_wr("ld.idle", 1'b0, 4'h0, 16'h0);
        chk("ld.busy.idle", 32'(busy_mask), 32'h0000);

        // Full queue with ALU continuously winning
        set_alu(1'b1, 4'h1, 16'h1001);
        set_mem(1'b1, 4'h4, 16'h1111);
        tick();
        chk_wr("full.e1", 1'b1, 4'h1, 16'h1001);
        chk("full.e1.cnt", 32'(lq_count), 32'd1);
        set_alu(1'b1, 4'h1, 16'h1002);
        set_mem(1'b1, 4'h6, 16'h2222);
        #1 chk("full.e1.rdy", 32'(mem_ready), 32'd1);
        tick();
        chk_wr("full.e2", 1'b1, 4'h1, 16'h1002);
        chk("full.e2.cnt", 32'(lq_count), 32'd2);
        chk("full.e2.rdy", 32'(mem_ready), 32'd0);
        chk("full.e2.busy", 32'(busy_mask), 32'h0052);
        set_alu(1'b1, 4'h1, 16'h1003);
        set_mem(1'b1, 4'h8, 16'h3333);
        #1 chk("full.e2.stall", 32'(alu_stall), 32'd0);
        tick();
        chk_wr("full.e3", 1'b1, 4'h1, 16'h1003);
        chk("full.e3.cnt", 32'(lq_count), 32'd2);
        chk("full.e3.rdy", 32'(mem_ready), 32'd0);
        set_alu(1'b1, 4'h1, 16'h1004);
        tick();
        chk_wr("full.e4", 1'b1, 4'h1, 16'h1004);
        chk("full.e4.cnt", 32'(lq_count), 32'd2);
        set_alu(1'b0, 4'h0, 16'h0);
        for (int i = 0; i < 8; i++) begin
            #1 hs = mem_valid && mem_ready;
            tick();
            if (hs) set_mem(1'b0, 4'h0, 16'h0);
            if (reg_w_enable && nrec < 8) begin
                rec_addr[nrec] = reg_w_addr;
                rec_val[nrec]  = reg_w_val;
                nrec++;
            end
        end
        chk("full.nwr", 32'(nrec), 32'd3);
        chk("full.w0.addr", 32'(rec_addr[0]), 32'h4);
        chk("full.w0.val", 32'(rec_val[0]), 32'h1111);
        chk("full.w1.addr", 32'(rec_addr[1]), 32'h6);
        chk("full.w1.val", 32'(rec_val[1]), 32'h2222);
        chk("full.w2.addr", 32'(rec_addr[2]), 32'h8);
        chk("full.w2.val", 32'(rec_val[2]), 32'h3333);
        chk("full.drain.cnt", 32'(lq_count), 32'd0);
        chk("full.drain.mv", 32'(mem_valid), 32'd0);

        // Starvation: four ALU wins, then a forced pop
        set_alu(1'b1, 4'h9, 16'h5000);
        set_mem(1'b1, 4'h7, 16'hAAAA);
        tick();
        set_mem(1'b0, 4'h0, 16'h0);
        chk_wr("stv.push", 1'b1, 4'h9, 16'h5000);
        chk("stv.cnt", 32'(lq_count), 32'd1);
        for (int i = 0; i < 4; i++) begin
            set_alu(1'b1, 4'h9, 16'h5001 + 16'(i));
            #1 chk("stv.nostall", 32'(alu_stall), 32'd0);
            tick();
            chk_wr("stv.win", 1'b1, 4'h9, 16'h5001 + 16'(i));
        end
        #1 chk("stv.stall", 32'(alu_stall), 32'd1);
        tick();
        chk_wr("stv.forced", 1'b1, 4'h7, 16'hAAAA);
        chk("stv.cnt0", 32'(lq_count), 32'd0);
        #1 chk("stv.after.stall", 32'(alu_stall), 32'd0);
        set_alu(1'b0, 4'h0, 16'h0);
        tick();
        chk_wr("stv.idle", 1'b0, 4'h0, 16'h0);

        // Zero register on both sides
        set_alu(1'b1, 4'hF, 16'h7777);
        set_mem(1'b1, 4'h2, 16'h0042);
        tick();
        chk_wr("zr.aluF", 1'b0, 4'h0, 16'h0);
        chk("zr.cnt1", 32'(lq_count), 32'd1);
        chk("zr.busy", 32'(busy_mask), 32'h0004);
        set_mem(1'b1, 4'hF, 16'hDEAD);
        #1 chk("zr.rdy", 32'(mem_ready), 32'd1);
        chk("zr.stall", 32'(alu_stall), 32'd0);
        tick();
        set_alu(1'b0, 4'h0, 16'h0);
        set_mem(1'b0, 4'h0, 16'h0);
        chk_wr("zr.pop", 1'b1, 4'h2, 16'h0042);
        chk("zr.cnt0", 32'(lq_count), 32'd0);
        chk("zr.busy.wr", 32'(busy_mask), 32'h0004);
        tick();
        chk_wr("zr.idle", 1'b0, 4'h0, 16'h0);
        chk("zr.idle.cnt", 32'(lq_count), 32'd0);
        chk("zr.idle.busy", 32'(busy_mask), 32'h0000);

        // Asynchronous reset in the middle of activity
        set_alu(1'b1, 4'h1, 16'h0101);
        set_mem(1'b1, 4'h3, 16'h3333);
        tick();
        set_alu(1'b1, 4'h1, 16'h0102);
        set_mem(1'b1, 4'h4, 16'h4444);
        tick();
        set_alu(1'b0, 4'h0, 16'h0);
        set_mem(1'b0, 4'h0, 16'h0);
        chk("mrst.pre.cnt", 32'(lq_count), 32'd2);
        chk_wr("mrst.pre", 1'b1, 4'h1, 16'h0102);
        #2 reset_n = 1'b0;
        #1 chk_reset_state("mrst");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mrst.post.en", 32'(reg_w_enable), 32'd0);
            chk("mrst.post.cnt", 32'(lq_count), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
